line_window_3x3: RTL and testbench

Sliding 3×3 neighbourhood generator that sits directly downstream of the pixel FIFO in the openCV image pipeline. It drains raster-ordered pixels through the FIFO's `re`/`empty`/`q` interface and keeps two line buffers of history. It emits one 3×3 window per interior pixel to the filter stage over a valid/ready handshake with full backpressure. Sustained throughput is one pixel per cycle when neither side stalls.

---
 rtl/line_window_pkg.sv | 18 +
 rtl/line_buffer.sv | 25 ++
 rtl/line_window_3x3.sv | 206 ++++++++++++++++++++
 tb/tb_line_window_3x3.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_window_pkg.sv
// Shared constants and helpers for the 3x3 line-window generator.
package line_window_pkg;

  localparam int unsigned WIN_DIM  = 3;
  localparam int unsigned WIN_TAPS = 9;

  // Where the pixel considered for acceptance this cycle comes from.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HOLD = 2'd1,
    SRC_FIFO = 2'd2
  } pix_src_e;

  function automatic int unsigned tap_idx(input int unsigned row, input int unsigned col);
    return row * WIN_DIM + col;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel history: combinational read and synchronous write at one address.
module line_buffer
  import line_window_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/line_window_3x3.sv
// Sliding 3x3 window generator fed from a raster-order pixel FIFO.
// Optional LINE_WINDOW_MARKERS_EN adds out_sof/out_eol frame markers.
module line_window_3x3
  import line_window_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 48
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      fifo_empty,
  input  logic [WIDTH-1:0]          fifo_q,
  output logic                      fifo_re,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIN_TAPS*WIDTH-1:0] out_win
`ifdef LINE_WINDOW_MARKERS_EN
  ,
  output logic                      out_sof,
  output logic                      out_eol
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN_DIM - 1);

  logic             rd_pending_q, rd_pending_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] win_q [WIN_DIM][WIN_DIM];
  logic [WIDTH-1:0] win_d [WIN_DIM][WIN_DIM];

  logic             stall;
  logic             accept;
  pix_src_e         pix_src;
  logic [WIDTH-1:0] pix;
  logic [WIDTH-1:0] lb0_rdata, lb1_rdata;

  // Handshake, read enable and pixel selection
  always_comb begin
    stall   = out_valid_q && !out_ready;
    fifo_re = resetn && !fifo_empty && !hold_valid_q && !(rd_pending_q && stall);

    if (hold_valid_q) begin
      pix_src = SRC_HOLD;
    end else if (rd_pending_q) begin
      pix_src = SRC_FIFO;
    end else begin
      pix_src = SRC_NONE;
    end

    accept = (pix_src != SRC_NONE) && !stall;
    pix    = (pix_src == SRC_HOLD) ? hold_data_q : fifo_q;
  end

  // A read issued before the stall was visible lands in the hold register.
  always_comb begin
    rd_pending_d = fifo_re;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (rd_pending_q && stall) begin
      hold_valid_d = 1'b1;
      hold_data_d  = fifo_q;
    end else if (accept && (pix_src == SRC_HOLD)) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      for (int unsigned c = 0; c < WIN_DIM; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (accept) begin
      for (int unsigned r = 0; r < WIN_DIM; r++) begin
        for (int unsigned c = 0; c < WIN_DIM - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][WIN_DIM-1] = lb1_rdata;
      win_d[1][WIN_DIM-1] = lb0_rdata;
      win_d[2][WIN_DIM-1] = pix;
    end

    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pending_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      for (int unsigned r = 0; r < WIN_DIM; r++) begin
        for (int unsigned c = 0; c < WIN_DIM; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      rd_pending_q <= rd_pending_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      for (int unsigned r = 0; r < WIN_DIM; r++) begin
        for (int unsigned c = 0; c < WIN_DIM; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W)
  ) lb0 (
    .clk   (clk),
    .we    (accept && resetn),
    .addr  (col_q),
    .wdata (pix),
    .rdata (lb0_rdata)
  );

  line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W)
  ) lb1 (
    .clk   (clk),
    .we    (accept && resetn),
    .addr  (col_q),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  always_comb begin
    out_valid = out_valid_q;
    out_win   = '0;
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      for (int unsigned c = 0; c < WIN_DIM; c++) begin
        out_win[tap_idx(r, c)*WIDTH +: WIDTH] = win_q[r][c];
      end
    end
  end

`ifdef LINE_WINDOW_MARKERS_EN
  logic out_sof_q, out_sof_d;
  logic out_eol_q, out_eol_d;

  always_comb begin
    out_sof_d = out_sof_q;
    out_eol_d = out_eol_q;
    if (accept) begin
      out_sof_d = (row_q == ROW_FIRST) && (col_q == COL_FIRST);
      out_eol_d = (row_q >= ROW_FIRST) && (col_q == COL_LAST);
    end else if (out_ready) begin
      out_sof_d = 1'b0;
      out_eol_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_sof_q <= 1'b0;
      out_eol_q <= 1'b0;
    end else begin
      out_sof_q <= out_sof_d;
      out_eol_q <= out_eol_d;
    end
  end

  assign out_sof = out_sof_q;
  assign out_eol = out_eol_q;
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 (IMG_W=4, IMG_H=3) against a frame-level window model.
module tb_line_window_3x3;

  localparam int W    = 16;
  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int TAPS = 9;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [W-1:0]    fifo_q = '0;
  logic            fifo_re;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TAPS*W-1:0] out_win;
`ifdef LINE_WINDOW_MARKERS_EN
  logic            out_sof, out_eol;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [W-1:0]      fifo_mem[$];
  logic [TAPS*W-1:0] exp_win[$];
  logic [TAPS*W-1:0] rx_win[$];
  bit                exp_sof[$], exp_eol[$], rx_sof[$], rx_eol[$];
  int                rx_cyc[$];
  int                rd_cyc[$];

  line_window_3x3 #(
    .WIDTH (W),
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_re    (fifo_re),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_win    (out_win)
`ifdef LINE_WINDOW_MARKERS_EN
    ,
    .out_sof    (out_sof),
    .out_eol    (out_eol)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on fifo_q the cycle after fifo_re.
  always @(posedge clk) begin
    if (fifo_re) fifo_q <= fifo_mem.pop_front();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // rmode: 0 ready, 1 not ready, 2 random. emode: 0 none, 1 toggle, 2 random gaps.
  task automatic cycle(input int rmode, input int emode, input logic rstn);
    bit gate;
    @(negedge clk);
    cyc++;
    resetn = rstn;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    case (emode)
      0:       gate = 1'b0;
      1:       gate = (cyc % 2 == 1);
      default: gate = ($urandom_range(0, 3) == 0);
    endcase
    fifo_empty = (fifo_mem.size() == 0) || gate;
    #1;
    if (fifo_re) rd_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      rx_win.push_back(out_win);
      rx_cyc.push_back(cyc);
`ifdef LINE_WINDOW_MARKERS_EN
      rx_sof.push_back(out_sof);
      rx_eol.push_back(out_eol);
`endif
    end
  endtask

  task automatic run_until(input int want, input int rmode, input int emode, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      cycle(rmode, emode, 1'b1);
      if (rx_win.size() >= want && fifo_mem.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) cycle(0, 0, 1'b1);
  endtask

  task automatic clear_logs();
    exp_win.delete(); exp_sof.delete(); exp_eol.delete();
    rx_win.delete();  rx_sof.delete();  rx_eol.delete();
    rx_cyc.delete();  rd_cyc.delete();
  endtask

  // Reference: push one frame and derive every interior window straight from the image.
  task automatic load_frame(input bit rnd);
    logic [W-1:0]      img [IH][IW];
    logic [TAPS*W-1:0] w;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        img[r][c] = rnd ? W'($urandom) : W'(r * 16 + c);
        fifo_mem.push_back(img[r][c]);
      end
    end
    for (int r = 2; r < IH; r++) begin
      for (int c = 2; c < IW; c++) begin
        for (int k = 0; k < TAPS; k++) w[k*W +: W] = img[r-2+k/3][c-2+k%3];
        exp_win.push_back(w);
        exp_sof.push_back(r == 2 && c == 2);
        exp_eol.push_back(c == IW - 1);
      end
    end
  endtask

  task automatic test_reset();
    clear_logs();
    load_frame(1'b0);
    repeat (3) cycle(0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_win !== '0) begin n_err++; $display("FAIL reset_win: got %h want 0", out_win); end
    n_checks++;
    if (fifo_re !== 1'b0) begin n_err++; $display("FAIL reset_re: got %b want 0", fifo_re); end
  endtask

  task automatic test_preloaded();
    bit ok;
    run_until(exp_win.size(), 0, 0, ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL preload_timeout: got %0d windows want %0d", rx_win.size(), exp_win.size()); end
    n_checks++;
    if (rx_win.size() != exp_win.size()) begin n_err++; $display("FAIL preload_count: got %0d want %0d", rx_win.size(), exp_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_checks++;
      if (rx_win[i] !== exp_win[i]) begin n_err++; $display("FAIL preload_win%0d: got %h want %h", i, rx_win[i], exp_win[i]); end
`ifdef LINE_WINDOW_MARKERS_EN
      n_checks++;
      if (rx_sof[i] !== exp_sof[i] || rx_eol[i] !== exp_eol[i])
        begin n_err++; $display("FAIL preload_mark%0d: got sof=%b eol=%b want sof=%b eol=%b", i, rx_sof[i], rx_eol[i], exp_sof[i], exp_eol[i]); end
`endif
    end
    n_checks++;
    if (rd_cyc.size() < 11 || rx_cyc.size() < 1 || rx_cyc[0] != rd_cyc[10] + 2)
      begin n_err++; $display("FAIL preload_latency: got first window at cycle %0d, want read-of-34 + 2", rx_cyc.size() > 0 ? rx_cyc[0] : -1); end
    n_checks++;
    if (rx_cyc.size() < 2 || rx_cyc[1] != rx_cyc[0] + 1)
      begin n_err++; $display("FAIL preload_b2b: got gap %0d want 1", rx_cyc.size() > 1 ? rx_cyc[1] - rx_cyc[0] : -1); end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    load_frame(1'b0);
    load_frame(1'b0);
    run_until(exp_win.size(), 0, 0, ok);
    n_checks++;
    if (!ok || rx_win.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", rx_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_checks++;
      if (rx_win[i] !== exp_win[i]) begin n_err++; $display("FAIL b2b_win%0d: got %h want %h", i, rx_win[i], exp_win[i]); end
    end
    n_checks++;
    if (rx_win.size() < 3 || rx_win[2] !== rx_win[0]) begin n_err++; $display("FAIL b2b_repeat: third window differs from first"); end
    n_checks++;
    if (rd_cyc.size() != 24 || rd_cyc[23] - rd_cyc[0] != 23)
      begin n_err++; $display("FAIL b2b_gap: got %0d reads spanning %0d cycles want 24 spanning 23", rd_cyc.size(), rd_cyc.size() > 0 ? rd_cyc[rd_cyc.size()-1] - rd_cyc[0] : -1); end
    clear_logs();
  endtask

  task automatic test_stall();
    bit ok;
    int n_rd0;
    clear_logs();
    load_frame(1'b0);
    load_frame(1'b0);
    for (int i = 0; i < 100 && rx_win.size() == 0; i++) cycle(0, 0, 1'b1);
    n_rd0 = rd_cyc.size();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_win !== exp_win[1])
        begin n_err++; $display("FAIL stall_hold%0d: got valid=%b win=%h want valid=1 win=%h", i, out_valid, out_win, exp_win[1]); end
      if (i >= 1) begin
        n_checks++;
        if (fifo_re !== 1'b0) begin n_err++; $display("FAIL stall_re%0d: got %b want 0", i, fifo_re); end
      end
    end
    n_checks++;
    if (rd_cyc.size() - n_rd0 > 1) begin n_err++; $display("FAIL stall_reads: got %0d reads want <=1", rd_cyc.size() - n_rd0); end
    run_until(exp_win.size(), 0, 0, ok);
    n_checks++;
    if (!ok || rx_win.size() != exp_win.size()) begin n_err++; $display("FAIL stall_count: got %0d want %0d", rx_win.size(), exp_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_checks++;
      if (rx_win[i] !== exp_win[i]) begin n_err++; $display("FAIL stall_win%0d: got %h want %h", i, rx_win[i], exp_win[i]); end
    end
    clear_logs();
  endtask

  task automatic test_empty_toggle();
    bit ok;
    clear_logs();
    load_frame(1'b0);
    run_until(exp_win.size(), 0, 1, ok);
    n_checks++;
    if (!ok || rx_win.size() != 2) begin n_err++; $display("FAIL empty_count: got %0d want 2", rx_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_checks++;
      if (rx_win[i] !== exp_win[i]) begin n_err++; $display("FAIL empty_win%0d: got %h want %h", i, rx_win[i], exp_win[i]); end
    end
    n_checks++;
    if (rx_cyc.size() < 2 || rx_cyc[1] - rx_cyc[0] != 2)
      begin n_err++; $display("FAIL empty_rate: got window gap %0d want 2", rx_cyc.size() > 1 ? rx_cyc[1] - rx_cyc[0] : -1); end
    n_checks++;
    if (rd_cyc.size() != 12 || rd_cyc[11] - rd_cyc[0] != 22)
      begin n_err++; $display("FAIL empty_reads: got %0d reads want 12 spanning 22 cycles", rd_cyc.size()); end
    clear_logs();
  endtask

  task automatic test_random();
    bit ok;
    clear_logs();
    repeat (3) load_frame(1'b1);
    run_until(exp_win.size(), 2, 2, ok);
    n_checks++;
    if (!ok || rx_win.size() != exp_win.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", rx_win.size(), exp_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_checks++;
      if (rx_win[i] !== exp_win[i]) begin n_err++; $display("FAIL rand_win%0d: got %h want %h", i, rx_win[i], exp_win[i]); end
`ifdef LINE_WINDOW_MARKERS_EN
      n_checks++;
      if (rx_sof[i] !== exp_sof[i] || rx_eol[i] !== exp_eol[i])
        begin n_err++; $display("FAIL rand_mark%0d: got sof=%b eol=%b want sof=%b eol=%b", i, rx_sof[i], rx_eol[i], exp_sof[i], exp_eol[i]); end
`endif
    end
    clear_logs();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_logs();
    for (int i = 0; i < 7; i++) fifo_mem.push_back(W'(i * 3 + 100));
    for (int i = 0; i < 50 && rd_cyc.size() < 7; i++) cycle(0, 0, 1'b1);
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || fifo_re !== 1'b0)
      begin n_err++; $display("FAIL midreset_state: got valid=%b re=%b want 0 0", out_valid, fifo_re); end
    clear_logs();
    load_frame(1'b0);
    run_until(exp_win.size(), 0, 0, ok);
    n_checks++;
    if (!ok || rx_win.size() != 2) begin n_err++; $display("FAIL midreset_count: got %0d want 2", rx_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_checks++;
      if (rx_win[i] !== exp_win[i]) begin n_err++; $display("FAIL midreset_win%0d: got %h want %h", i, rx_win[i], exp_win[i]); end
    end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_preloaded();
    test_back_to_back();
    test_stall();
    test_empty_toggle();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
